// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the memory-mapped UART transmitter:
//     - tx_state_e   : transmitter FSM states (IDLE, START, DATA, STOP)
//     - TXDATA_OFS / STATUS_OFS : register offsets inside the 8-byte window
//     - ST_*         : bit positions of the STATUS register fields
//     - sat_count()  : clamps a FIFO occupancy to the 4-bit STATUS field
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    localparam logic [2:0] TXDATA_OFS = 3'h0;
    localparam logic [2:0] STATUS_OFS = 3'h4;

    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_BUSY    = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 4;
    localparam int ST_CNT_W   = 4;
    localparam int ST_IE      = 8;

    // Occupancy as shown in STATUS[7:4]; deeper FIFOs read back as 15.
    function automatic logic [ST_CNT_W-1:0] sat_count(input logic [31:0] c);
        return (c > 32'd15) ? 4'hF : c[ST_CNT_W-1:0];
    endfunction

endpackage

// File: rtl/tx_fifo.sv
// ---------------------------------------------------------------------------
// tx_fifo
//   Synchronous FIFO holding bytes waiting to be serialised.
//   Ports:
//     clk, srst        : clock and synchronous active-high reset
//     push, push_data  : write request and data; accepted when not full, or
//                        when a pop happens on the same edge
//     pop, pop_data    : read request; pop_data is the current head entry
//                        (valid whenever empty is low)
//     full, empty      : occupancy flags
//     count            : number of stored entries (clog2(DEPTH)+1 bits)
//   DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module tx_fifo #(
    parameter  int DEPTH = 8,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push;
    logic             do_pop;

    assign full     = (count_reg == CW'(DEPTH));
    assign empty    = (count_reg == '0);
    assign count    = count_reg;
    assign pop_data = mem[rd_ptr_reg];

    assign do_pop  = pop && !empty;
    // A pop on the same edge frees the slot the push needs.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push && !srst) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// ---------------------------------------------------------------------------
// mmio_uart_tx
//   Memory-mapped 8N1 serial transmitter sitting beside the data memory.
//   Stores to BASE+0 queue DataIn[7:0] in a FIFO; the FSM shifts queued bytes
//   out LSB first, each bit lasting CLK_DIV clocks. BASE+4 is STATUS.
//
//   Ports:
//     CLK      : system clock, rising edge
//     Reset    : synchronous active-high reset
//     DataWr   : store strobe
//     Digit    : access width (unused, only DataIn[7:0] is transmitted)
//     DAddr    : bus address
//     DataIn   : store data
//     DataOut  : combinational read data (STATUS at BASE+4, else 0)
//     Hit      : DAddr lies in the 8-byte window
//     tx       : registered serial line, idle high
//     Busy     : a frame is in progress (registered)
//     Irq      : only with UART_TX_IRQ_EN defined; ie && empty && !Busy,
//                registered
//
//   Build option: define UART_TX_IRQ_EN to add the Irq output and the
//   STATUS[8] interrupt-enable bit.
// ---------------------------------------------------------------------------
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000,
    parameter logic [15:0] CLK_DIV    = 16'd434,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        DataWr,
    input  logic [1:0]  Digit,
    input  logic [31:0] DAddr,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        Hit,
    output logic        tx,
    output logic        Busy
`ifdef UART_TX_IRQ_EN
    ,
    output logic        Irq
`endif
);

    localparam int          CW          = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] BAUD_RELOAD = CLK_DIV - 16'd1;

    // -----------------------------------------------------------------------
    // Bus decode
    // -----------------------------------------------------------------------
    logic [2:0] reg_ofs;
    logic       wr_txdata;
    logic       wr_status;
    logic       rd_status;

    assign Hit       = (DAddr[31:3] == BASE_ADDR[31:3]);
    // Byte lanes within a word are ignored, so only DAddr[2] picks the register.
    assign reg_ofs   = {DAddr[2], 2'b00};
    assign wr_txdata = DataWr && Hit && (reg_ofs == TXDATA_OFS);
    assign wr_status = DataWr && Hit && (reg_ofs == STATUS_OFS);
    assign rd_status = Hit && (reg_ofs == STATUS_OFS);

    // -----------------------------------------------------------------------
    // FIFO
    // -----------------------------------------------------------------------
    logic          fifo_pop;
    logic [7:0]    fifo_data;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (CLK),
        .srst      (Reset),
        .push      (wr_txdata),
        .push_data (DataIn[7:0]),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // -----------------------------------------------------------------------
    // Transmit FSM
    // -----------------------------------------------------------------------
    tx_state_e   state_reg;
    tx_state_e   state_next;
    logic [15:0] baud_reg;
    logic [15:0] baud_next;
    logic [2:0]  bit_idx_reg;
    logic [2:0]  bit_idx_next;
    logic [7:0]  shift_reg;
    logic [7:0]  shift_next;
    logic        tx_reg;
    logic        tx_next;
    logic        busy_reg;
    logic        busy_next;
    logic        baud_done;

    assign baud_done = (baud_reg == 16'd0);

    // State register
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_reg   <= IDLE;
            baud_reg    <= 16'd0;
            bit_idx_reg <= 3'd0;
            shift_reg   <= 8'd0;
            tx_reg      <= 1'b1;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            baud_reg    <= baud_next;
            bit_idx_reg <= bit_idx_next;
            shift_reg   <= shift_next;
            tx_reg      <= tx_next;
            busy_reg    <= busy_next;
        end
    end

    // Next-state logic: every non-idle state lasts CLK_DIV clocks, the baud
    // counter being reloaded with CLK_DIV-1 on entry and expiring at zero.
    always_comb begin
        state_next   = state_reg;
        baud_next    = baud_reg;
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        fifo_pop     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    shift_next = fifo_data;
                    baud_next  = BAUD_RELOAD;
                    state_next = START;
                end
            end
            START: begin
                if (baud_done) begin
                    baud_next    = BAUD_RELOAD;
                    bit_idx_next = 3'd0;
                    state_next   = DATA;
                end else begin
                    baud_next = baud_reg - 16'd1;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_next = BAUD_RELOAD;
                    if (bit_idx_reg == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        shift_next   = {1'b0, shift_reg[7:1]};
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end else begin
                    baud_next = baud_reg - 16'd1;
                end
            end
            STOP: begin
                if (baud_done) begin
                    state_next = IDLE;
                end else begin
                    baud_next = baud_reg - 16'd1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output logic: tx and Busy are derived from the state being entered so
    // the registered line changes on the same edge as the state.
    always_comb begin
        tx_next   = 1'b1;
        busy_next = (state_next != IDLE);
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            default: tx_next = 1'b1;
        endcase
    end

    assign tx   = tx_reg;
    assign Busy = busy_reg;

    // -----------------------------------------------------------------------
    // Sticky overflow flag: a push to a full FIFO with no pop on that edge
    // loses the byte.
    // -----------------------------------------------------------------------
    logic ovf_reg;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            ovf_reg <= 1'b0;
        end else if (wr_status) begin
            ovf_reg <= 1'b0;
        end else if (wr_txdata && fifo_full && !fifo_pop) begin
            ovf_reg <= 1'b1;
        end
    end

`ifdef UART_TX_IRQ_EN
    // -----------------------------------------------------------------------
    // Interrupt: raised once the FIFO has drained and the last frame is done.
    // -----------------------------------------------------------------------
    logic ie_reg;
    logic irq_reg;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            ie_reg  <= 1'b0;
            irq_reg <= 1'b0;
        end else begin
            if (wr_status) begin
                ie_reg <= DataIn[ST_IE];
            end
            irq_reg <= ie_reg && fifo_empty && !busy_reg;
        end
    end

    assign Irq = irq_reg;
`endif

    // -----------------------------------------------------------------------
    // Read mux
    // -----------------------------------------------------------------------
    logic [31:0] status_word;

    always_comb begin
        status_word                                = 32'd0;
        status_word[ST_FULL]                       = fifo_full;
        status_word[ST_EMPTY]                      = fifo_empty;
        status_word[ST_BUSY]                       = busy_reg;
        status_word[ST_OVF]                        = ovf_reg;
        status_word[ST_CNT_LSB +: ST_CNT_W]        = sat_count(32'(fifo_count));
`ifdef UART_TX_IRQ_EN
        status_word[ST_IE]                         = ie_reg;
`endif
        DataOut = rd_status ? status_word : 32'd0;
    end

    // Inputs that carry no information for this peripheral.
    logic unused_bits;
`ifdef UART_TX_IRQ_EN
    assign unused_bits = ^{Digit, DataIn[31:9], DAddr[1:0]};
`else
    assign unused_bits = ^{Digit, DataIn[31:8], DAddr[1:0]};
`endif

endmodule

// File: tb/tb_mmio_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_mmio_uart_tx
//   Randomised scoreboard bench for mmio_uart_tx (CLK_DIV = 4, depth 8).
//   The driver keeps a transaction-level model (byte queue, frame start
//   times, flags) and pushes every expected frame into exp_q; an independent
//   serial monitor watches tx, pops exp_q on each start bit and compares the
//   whole 40-cycle waveform. Bus-visible outputs are compared every cycle.
// ---------------------------------------------------------------------------
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE  = 32'hFFFF_0000;
    localparam int          DIV   = 4;
    localparam int          DEPTH = 8;
    localparam int          FL    = 10 * DIV;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        DataWr;
    logic [1:0]  Digit;
    logic [31:0] DAddr;
    logic [31:0] DataIn;
    logic [31:0] DataOut;
    logic        Hit;
    logic        tx;
    logic        Busy;
`ifdef UART_TX_IRQ_EN
    logic        Irq;
`endif

    always #5 CLK = ~CLK;

    mmio_uart_tx #(
        .BASE_ADDR  (BASE),
        .CLK_DIV    (16'(DIV)),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .CLK     (CLK),
        .Reset   (Reset),
        .DataWr  (DataWr),
        .Digit   (Digit),
        .DAddr   (DAddr),
        .DataIn  (DataIn),
        .DataOut (DataOut),
        .Hit     (Hit),
        .tx      (tx),
        .Busy    (Busy)
`ifdef UART_TX_IRQ_EN
        ,
        .Irq     (Irq)
`endif
    );

    // ---------------- reference model state ----------------
    typedef struct {
        logic [7:0] data;
        int         start;
    } exp_t;

    int          checks   = 0;
    int          errors   = 0;
    int          edge_cnt = 0;
    logic [31:0] base_v   = BASE;
    logic [7:0]  mq[$];
    exp_t        exp_q[$];
    int          last_pop = -1000;
    bit          ovf_m    = 1'b0;
    bit          ie_m     = 1'b0;
    bit          irq_m    = 1'b0;
    bit          abort_req = 1'b0;
    bit          in_frame  = 1'b0;
    bit          mon_en    = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (edge %0d)", name, act, req, edge_cnt);
        end
    endtask

    // A frame occupies the 40 edges following (and including) its pop edge.
    function automatic bit busy_at(input int k);
        return (k >= last_pop) && (k < last_pop + FL);
    endfunction

    function automatic bit hit_of(input logic [31:0] a);
        return a[31:3] == base_v[31:3];
    endfunction

    function automatic logic [31:0] status_exp();
        logic [31:0] w;
        int          sz;
        sz   = mq.size();
        w    = 32'd0;
        w[0] = (sz == DEPTH);
        w[1] = (sz == 0);
        w[2] = busy_at(edge_cnt);
        w[3] = ovf_m;
        w[7:4] = (sz > 15) ? 4'hF : 4'(sz);
`ifdef UART_TX_IRQ_EN
        w[8] = ie_m;
`endif
        return w;
    endfunction

    function automatic logic [FL-1:0] frame_bits(input logic [7:0] d);
        logic [FL-1:0] v;
        int            b;
        v = '0;
        for (int i = 0; i < FL; i++) begin
            b = i / DIV;
            if (b == 0)      v[i] = 1'b0;
            else if (b == 9) v[i] = 1'b1;
            else             v[i] = d[b-1];
        end
        return v;
    endfunction

    // Apply the bus rules for one rising edge.
    task automatic model_edge(input bit wr, input logic [31:0] addr,
                              input logic [31:0] data, input bit rst);
        int  k;
        int  sz;
        bit  pop;
        bit  irq_n;
        exp_t it;
        edge_cnt++;
        k = edge_cnt;
        if (rst) begin
            if (busy_at(k - 1)) abort_req = 1'b1;
            mq.delete();
            ovf_m    = 1'b0;
            ie_m     = 1'b0;
            irq_m    = 1'b0;
            last_pop = -1000;
        end else begin
            sz    = mq.size();
            irq_n = ie_m && (sz == 0) && !busy_at(k - 1);
            pop   = !busy_at(k - 1) && (sz > 0);
            if (pop) begin
                it.data  = mq.pop_front();
                it.start = k;
                exp_q.push_back(it);
                last_pop = k;
            end
            if (wr && hit_of(addr) && !addr[2]) begin
                if (sz < DEPTH || pop) mq.push_back(data[7:0]);
                else                   ovf_m = 1'b1;
            end
            if (wr && hit_of(addr) && addr[2]) begin
                ovf_m = 1'b0;
                ie_m  = data[8];
            end
            irq_m = irq_n;
        end
    endtask

    // One bus cycle: drive, check combinational/registered outputs, clock.
    task automatic step(input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, input bit rst);
        logic [31:0] exp_do;
        Reset  = rst;
        DataWr = wr;
        DAddr  = addr;
        DataIn = data;
        Digit  = 2'($urandom_range(0, 2));
        #1;
        if (mon_en) begin
            chk("hit", Hit, hit_of(addr));
            exp_do = (hit_of(addr) && addr[2]) ? status_exp() : 32'd0;
            chk("dataout", DataOut, exp_do);
            chk("busy", Busy, busy_at(edge_cnt));
`ifdef UART_TX_IRQ_EN
            chk("irq", Irq, irq_m);
`endif
        end
        @(posedge CLK);
        model_edge(wr, addr, data, rst);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, BASE + 32'h4, 32'd0, 1'b0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() > 0 || in_frame || mq.size() > 0 || busy_at(edge_cnt)) && n < 3000) begin
            step(1'b0, BASE + 32'h4, 32'd0, 1'b0);
            n++;
        end
        chk("drain_within_bound", n < 3000, 1'b1);
    endtask

    // ---------------- serial monitor ----------------
    initial begin
        logic [FL-1:0] samp;
        int            pos;
        exp_t          it;
        samp = '0;
        pos  = 0;
        forever begin
            @(posedge CLK);
            #1;
            if (mon_en) begin
                if (in_frame) begin
                    if (abort_req) begin
                        abort_req = 1'b0;
                        in_frame  = 1'b0;
                        chk("abort_tx_idle", tx, 1'b1);
                    end else begin
                        samp[pos] = tx;
                        pos++;
                        if (pos == FL) begin
                            in_frame = 1'b0;
                            chk("frame_bits", samp, frame_bits(it.data));
                            $display("frame byte=%02h start_edge=%0d", it.data, it.start);
                        end
                    end
                end else begin
                    abort_req = 1'b0;
                    if (tx !== 1'b1) begin
                        chk("frame_pending", exp_q.size() > 0, 1'b1);
                        if (exp_q.size() > 0) begin
                            it = exp_q.pop_front();
                            chk("frame_start_edge", edge_cnt, it.start);
                            samp    = '0;
                            samp[0] = tx;
                            pos     = 1;
                            in_frame = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        int          r;
        logic [31:0] a;
        logic [31:0] d;
        Reset  = 1'b1;
        DataWr = 1'b0;
        DAddr  = 32'd0;
        DataIn = 32'd0;
        Digit  = 2'd0;

        step(1'b0, 32'd0, 32'd0, 1'b1);
        step(1'b0, 32'd0, 32'd0, 1'b1);
        mon_en = 1'b1;

        // Reset state
        chk("rst_tx", tx, 1'b1);
        chk("rst_busy", Busy, 1'b0);
        DAddr = 32'd0;
        #1 chk("rst_hit_addr0", Hit, 1'b0);
        DAddr = BASE + 32'h4;
        #1 chk("rst_status", DataOut, 32'h2);

        // Single frame of 0x55
        step(1'b1, BASE, 32'hA5A5_A555, 1'b0);
        idle(45);
        DAddr = BASE + 32'h4;
        #1 chk("frame1_status", DataOut, 32'h2);

        // Ten back-to-back stores: one shifting, eight queued, one dropped
        for (int i = 0; i < 10; i++) step(1'b1, BASE, 32'(i), 1'b0);
        DataWr = 1'b0;
        DAddr  = BASE + 32'h4;
        #1 chk("ovf_status", DataOut, 32'h8D);
        step(1'b1, BASE + 32'h4, 32'd0, 1'b0);
        DataWr = 1'b0;
        #1 chk("ovf_cleared_status", DataOut, 32'h85);
        drain();

        // Reset in the middle of data bit 3 with a second byte queued
        step(1'b1, BASE, 32'h3C, 1'b0);
        step(1'b1, BASE, 32'hC3, 1'b0);
        while (edge_cnt < last_pop + 17) idle(1);
        step(1'b0, BASE + 32'h4, 32'd0, 1'b1);
        chk("midrst_tx", tx, 1'b1);
        chk("midrst_busy", Busy, 1'b0);
        DAddr = BASE + 32'h4;
        #1 chk("midrst_status", DataOut, 32'h2);
        idle(60);

        // Out-of-window store, register reads, ignored low address bits
        step(1'b1, BASE + 32'h8, 32'h77, 1'b0);
        idle(2);
        DAddr = BASE + 32'h4;
        #1 chk("no_push_status", DataOut, 32'h2);
        chk("status_hit", Hit, 1'b1);
        DAddr = BASE;
        #1 chk("txdata_read", DataOut, 32'h0);
        step(1'b1, BASE + 32'h3, 32'h5A, 1'b0);
        drain();

        // Randomised traffic, including resets and overflows
        for (int i = 0; i < 800; i++) begin
            r = $urandom_range(0, 99);
            d = $urandom;
            if (r < 30) begin
                step(1'b1, BASE + 32'($urandom_range(0, 3)), d, 1'b0);
            end else if (r < 36) begin
                step(1'b1, BASE + 32'h4 + 32'($urandom_range(0, 3)), d, 1'b0);
            end else if (r < 42) begin
                a = $urandom;
                if (a[31:3] == base_v[31:3]) a = a ^ 32'h8;
                step(1'b1, a, d, 1'b0);
            end else if (r < 44) begin
                step(1'($urandom_range(0, 1)), BASE, d, 1'b1);
            end else if (r < 80) begin
                step(1'b0, BASE + 32'h4, d, 1'b0);
            end else begin
                step(1'b0, BASE, d, 1'b0);
            end
        end
        drain();

        // Interrupt enable sequence
        step(1'b1, BASE + 32'h4, 32'h100, 1'b0);
        step(1'b1, BASE, 32'h41, 1'b0);
        idle(50);
        step(1'b1, BASE + 32'h4, 32'h0, 1'b0);
        idle(3);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
